// File: rtl/lcd_capture_if.sv
// lcd_capture_if: LCD scan-out inputs plus framebuffer write and per-frame status outputs.
// The master is the LCD source or test harness; the slave is the capture stage.
// All signals are synchronous to the capture clock.
interface lcd_capture_if #(
  parameter int ABITS = 15
);
  logic             hs;
  logic             vs;
  logic [1:0]       pixel;
  logic             valid;
  logic             fb_we;
  logic [ABITS-1:0] fb_addr;
  logic [1:0]       fb_data;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic [15:0]      frame_crc;
  logic             err_hlen;
  logic             err_vlen;

  modport master (
    output hs, vs, pixel, valid,
    input  fb_we, fb_addr, fb_data, frame_done, frame_cnt, frame_crc, err_hlen, err_vlen
  );

  modport slave (
    input  hs, vs, pixel, valid,
    output fb_we, fb_addr, fb_data, frame_done, frame_cnt, frame_crc, err_hlen, err_vlen
  );
endinterface

// File: rtl/lcd_capture.sv
// lcd_capture: writes visible LCD pixels into a 2bpp framebuffer, reports per-frame crc/count/geometry errors.
// Latency: framebuffer write 1 cycle after the pixel sample; frame_done 1 cycle after the vs rise.
// Backpressure: none; one pixel per cycle, out-of-geometry pixels are dropped and flagged.
module lcd_capture #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 144,
  parameter int ABITS    = 15
) (
  input  logic         clk,
  input  logic         rst,
  lcd_capture_if.slave bus
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]    X_END     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]    Y_END     = YW'(V_ACTIVE);
  localparam logic [ABITS-1:0] LINE_STEP = ABITS'(H_ACTIVE);
  localparam logic [15:0]      CRC_INIT  = 16'hFFFF;

  localparam logic [0:0] WAIT_VS = 1'b0;
  localparam logic [0:0] ACTIVE  = 1'b1;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [1:0] p);
    return {c[14:0], c[15]} ^ {14'b0, p};
  endfunction

  logic [0:0]       state, state_n;
  logic             hs_d, vs_d;
  logic [XW-1:0]    x, x_n;
  logic [YW-1:0]    y, y_n;
  logic [ABITS-1:0] line_base, lb_n;
  logic [15:0]      crc, crc_n;
  logic             hl, hl_n, vl, vl_n;

  logic             wr;
  logic [ABITS-1:0] wr_addr;
  logic             close;
  logic             hl_fin, vl_fin;

  logic             fb_we_q;
  logic [ABITS-1:0] fb_addr_q;
  logic [1:0]       fb_data_q;
  logic             frame_done_q;
  logic [15:0]      frame_cnt_q, frame_crc_q;
  logic             err_hlen_q, err_vlen_q;

  logic hs_rise, vs_rise;
  assign hs_rise = bus.hs & ~hs_d;
  assign vs_rise = bus.vs & ~vs_d;

  // Next-state for the frame walker: vs closes a frame (and may carry pixel 0 of the
  // next one), otherwise the pixel is placed first and a coincident hs then closes the line.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    lb_n    = line_base;
    crc_n   = crc;
    hl_n    = hl;
    vl_n    = vl;
    wr      = 1'b0;
    wr_addr = line_base + ABITS'(x);
    close   = 1'b0;
    hl_fin  = hl;
    vl_fin  = vl;
    if (state == WAIT_VS) begin
      if (vs_rise) begin
        state_n = ACTIVE;
        x_n     = '0;
        y_n     = '0;
        lb_n    = '0;
        crc_n   = CRC_INIT;
        hl_n    = 1'b0;
        vl_n    = 1'b0;
      end
    end else if (vs_rise) begin
      // An unterminated line still counts as a line and is length-checked.
      close  = 1'b1;
      hl_fin = hl | ((x != '0) && (x != X_END));
      vl_fin = vl | ((y + YW'(x != '0)) != Y_END);
      x_n    = '0;
      y_n    = '0;
      lb_n   = '0;
      crc_n  = CRC_INIT;
      hl_n   = 1'b0;
      vl_n   = 1'b0;
      if (bus.valid) begin
        wr      = 1'b1;
        wr_addr = '0;
        x_n     = XW'(1);
        crc_n   = crc_step(CRC_INIT, bus.pixel);
      end
    end else begin
      if (bus.valid) begin
        if (y == Y_END) begin
          vl_n = 1'b1;
        end else if (x == X_END) begin
          hl_n = 1'b1;
        end else begin
          wr    = 1'b1;
          x_n   = x + 1'b1;
          crc_n = crc_step(crc, bus.pixel);
        end
      end
      // Blanking hsyncs (empty line) are not counted.
      if (hs_rise && (x_n != '0)) begin
        if (x_n != X_END) hl_n = 1'b1;
        y_n  = y + 1'b1;
        lb_n = line_base + LINE_STEP;
        x_n  = '0;
      end
    end
  end

  // Sync edge-detect history and frame walker state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      state     <= WAIT_VS;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      crc       <= CRC_INIT;
      hl        <= 1'b0;
      vl        <= 1'b0;
    end else begin
      hs_d      <= bus.hs;
      vs_d      <= bus.vs;
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      line_base <= lb_n;
      crc       <= crc_n;
      hl        <= hl_n;
      vl        <= vl_n;
    end
  end

  // Registered framebuffer write port; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= 2'b0;
    end else begin
      fb_we_q <= wr;
      if (wr) begin
        fb_addr_q <= wr_addr;
        fb_data_q <= bus.pixel;
      end
    end
  end

  // Per-frame status, latched when a frame closes and held until the next close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
      frame_crc_q  <= 16'h0000;
      err_hlen_q   <= 1'b0;
      err_vlen_q   <= 1'b0;
    end else begin
      frame_done_q <= close;
      if (close) begin
        frame_cnt_q <= frame_cnt_q + 16'h0001;
        frame_crc_q <= crc;
        err_hlen_q  <= hl_fin;
        err_vlen_q  <= vl_fin;
      end
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.frame_crc  = frame_crc_q;
  assign bus.err_hlen   = err_hlen_q;
  assign bus.err_vlen   = err_vlen_q;

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed table-driven and full-frame checks for lcd_capture.
module tb_lcd_capture;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  lcd_capture_if #(.ABITS(15)) bus();

  lcd_capture #(.H_ACTIVE(160), .V_ACTIVE(144), .ABITS(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write / frame monitor
  int          hits [32768];
  logic [1:0]  wdat [32768];
  int          wr_total;
  int          done_cnt;
  logic [15:0] cap_cnt, cap_crc;
  logic        cap_hl, cap_vl;

  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) begin
      wr_total++;
      hits[bus.fb_addr]++;
      wdat[bus.fb_addr] = bus.fb_data;
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      cap_cnt = bus.frame_cnt;
      cap_crc = bus.frame_crc;
      cap_hl  = bus.err_hlen;
      cap_vl  = bus.err_vlen;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic va, input logic [1:0] p);
    @(negedge clk);
    bus.hs    = h;
    bus.vs    = v;
    bus.valid = va;
    bus.pixel = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // n pixels; hs either on the last pixel (coinc) or on a separate following cycle
  task automatic send_line(input int n, input bit coinc, input logic [1:0] first_pix);
    for (int i = 0; i < n; i++)
      drive(coinc && (i == n - 1), 1'b0, 1'b1, (i == 0) ? first_pix : 2'd0);
    if (!coinc) drive(1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic send_vs(input logic va, input logic [1:0] p);
    drive(1'b0, 1'b1, va, p);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic clear_mon();
    for (int a = 0; a < 32768; a++) begin
      hits[a] = 0;
      wdat[a] = 2'd0;
    end
    wr_total = 0;
  endtask

  // Count addresses whose write count differs from one-per-address over 0..last (except hole)
  task automatic audit(input int last, input int hole, output int nbad);
    nbad = 0;
    for (int a = 0; a < 32768; a++) begin
      int e;
      e = ((a <= last) && (a != hole)) ? 1 : 0;
      if (hits[a] != e) nbad++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},   64'(bus.fb_we),      64'd0);
    chk({tag, "_addr"}, 64'(bus.fb_addr),    64'd0);
    chk({tag, "_data"}, 64'(bus.fb_data),    64'd0);
    chk({tag, "_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_cnt"},  64'(bus.frame_cnt),  64'd0);
    chk({tag, "_crc"},  64'(bus.frame_crc),  64'h0000);
    chk({tag, "_hl"},   64'(bus.err_hlen),   64'd0);
    chk({tag, "_vl"},   64'(bus.err_vlen),   64'd0);
  endtask

  typedef struct {
    logic        hs, vs, valid;
    logic [1:0]  pixel;
    logic        e_we;
    logic [14:0] e_addr;
    logic [1:0]  e_data;
    logic        e_done;
    logic [15:0] e_cnt, e_crc;
    logic        e_hl, e_vl;
  } vec_t;

  vec_t tv [13];

  initial begin
    int nb;
    total = 0;
    bad = 0;
    wr_total = 0;
    done_cnt = 0;
    rst = 1'b1;
    bus.hs = 1'b0;
    bus.vs = 1'b0;
    bus.valid = 1'b0;
    bus.pixel = 2'd0;

    // hs vs valid pixel | we addr data done cnt crc hl vl
    tv[0]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 15'd0,   2'd0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 15'd0,   2'd0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 15'd0,   2'd0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 15'd0,   2'd2, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 15'd1,   2'd1, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 15'd1,   2'd1, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 15'd1,   2'd1, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 15'd160, 2'd3, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 15'd160, 2'd3, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 15'd320, 2'd0, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 15'd320, 2'd0, 1'b1, 16'd1, 16'hFFED, 1'b1, 1'b1};
    tv[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 15'd320, 2'd0, 1'b0, 16'd1, 16'hFFED, 1'b1, 1'b1};
    tv[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 15'd320, 2'd0, 1'b0, 16'd1, 16'hFFED, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;

    // Short cycle-accurate sequence: WAIT_VS ignores inputs, writes, line closes, frame close
    for (int r = 0; r < 13; r++) begin
      drive(tv[r].hs, tv[r].vs, tv[r].valid, tv[r].pixel);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", r),
          64'({bus.fb_we, bus.fb_addr, bus.fb_data, bus.frame_done, bus.frame_cnt,
               bus.frame_crc, bus.err_hlen, bus.err_vlen}),
          64'({tv[r].e_we, tv[r].e_addr, tv[r].e_data, tv[r].e_done, tv[r].e_cnt,
               tv[r].e_crc, tv[r].e_hl, tv[r].e_vl}));
    end
    chk("vec_done_cnt", 64'(done_cnt), 64'd1);
    clear_mon();

    // F1: full frame, pixel(0,0)=1, hs coincident with pixel 159 of every line
    for (int l = 0; l < 144; l++) send_line(160, 1'b1, (l == 0) ? 2'd1 : 2'd0);
    send_vs(1'b0, 2'd0);
    idle(2);
    chk("f1_done_cnt", 64'(done_cnt), 64'd2);
    chk("f1_cnt", 64'(cap_cnt), 64'd2);
    chk("f1_crc", 64'(cap_crc), 64'h7FFF);
    chk("f1_hl", 64'(cap_hl), 64'd0);
    chk("f1_vl", 64'(cap_vl), 64'd0);
    chk("f1_writes", 64'(wr_total), 64'd23040);
    audit(23039, -1, nb);
    chk("f1_addr_map", 64'(nb), 64'd0);
    chk("f1_data0", 64'(wdat[0]), 64'd1);
    chk("f1_hit_last_x", 64'(hits[143*160+159]), 64'd1);

    // F2: only 3 lines; closing vs carries pixel (0,0)=2 of F3
    for (int l = 0; l < 3; l++) send_line(160, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    clear_mon();
    send_vs(1'b1, 2'd2);
    idle(1);
    chk("f2_done_cnt", 64'(done_cnt), 64'd3);
    chk("f2_cnt", 64'(cap_cnt), 64'd3);
    chk("f2_crc", 64'(cap_crc), 64'hFFFF);
    chk("f2_hl", 64'(cap_hl), 64'd0);
    chk("f2_vl", 64'(cap_vl), 64'd1);

    // F3: line 5 short (159), line 6 long (161)
    send_line(159, 1'b0, 2'd0);
    for (int l = 1; l < 144; l++) send_line((l == 5) ? 159 : ((l == 6) ? 161 : 160), 1'b0, 2'd0);
    send_vs(1'b0, 2'd0);
    idle(2);
    chk("f3_done_cnt", 64'(done_cnt), 64'd4);
    chk("f3_cnt", 64'(cap_cnt), 64'd4);
    chk("f3_crc", 64'(cap_crc), 64'h7FFF);
    chk("f3_hl", 64'(cap_hl), 64'd1);
    chk("f3_vl", 64'(cap_vl), 64'd0);
    chk("f3_writes", 64'(wr_total), 64'd23039);
    audit(23039, 959, nb);
    chk("f3_addr_map", 64'(nb), 64'd0);
    chk("f3_data0", 64'(wdat[0]), 64'd2);
    chk("f3_hit960", 64'(hits[960]), 64'd1);

    // F4: reset mid-line
    for (int l = 0; l < 2; l++) send_line(160, 1'b0, 2'd0);
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b0, 1'b1, 2'd1);
    @(posedge clk);
    #1;
    chk("f4_pre_we", 64'(bus.fb_we), 64'd1);
    chk("f4_pre_addr", 64'(bus.fb_addr), 64'd369);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    idle(2);
    rst = 1'b0;
    send_vs(1'b0, 2'd0);
    idle(3);
    chk("post_rst_vs_no_done", 64'(done_cnt), 64'd4);
    @(posedge clk);
    #1;
    clear_mon();

    // F5: full all-zero frame after reset
    for (int l = 0; l < 144; l++) send_line(160, 1'b0, 2'd0);
    send_vs(1'b0, 2'd0);
    idle(2);
    chk("f5_done_cnt", 64'(done_cnt), 64'd5);
    chk("f5_cnt", 64'(cap_cnt), 64'd1);
    chk("f5_crc", 64'(cap_crc), 64'hFFFF);
    chk("f5_hl", 64'(cap_hl), 64'd0);
    chk("f5_vl", 64'(cap_vl), 64'd0);
    chk("f5_writes", 64'(wr_total), 64'd23040);
    audit(23039, -1, nb);
    chk("f5_addr_map", 64'(nb), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
